// File: rtl/bus_capture_fifo_if.sv
// Signal bundle between the bus sequencer / consumer side and the capture FIFO.
// Handshake: a word is taken from BUS on a rising clk edge where load is high
// and the FIFO can accept it (not full, or popping in the same cycle); the head
// word on DOUT is consumed on a rising edge where pop is high and empty is low.
// Neither side waits on the other: rejected loads and pops only set sticky flags.
interface bus_capture_fifo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic [WIDTH-1:0] BUS;
    logic             load;
    logic             pop;
    logic             clear_err;
    logic [WIDTH-1:0] DOUT;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    // Sequencer/consumer side: drives the bus and strobes, observes FIFO state.
    modport master (
        output BUS, load, pop, clear_err,
        input  DOUT, empty, full, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  BUS, load, pop, clear_err,
        output DOUT, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/bus_capture_fifo.sv
// Reader end of the shared tri-state data bus: samples BUS on load into a small
// show-ahead FIFO and hands words to a downstream consumer on pop.
module bus_capture_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic               clk,
    input logic               reset,
    bus_capture_fifo_if.slave io
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             is_empty;
    logic             is_full;
    logic             wr;
    logic             rd;

    // Status is decoded from the registered count so it never glitches on inputs.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a load
    // when popping. A pop on an empty FIFO is never accepted, even with a load.
    assign wr = io.load && (!is_full || io.pop);
    assign rd = io.pop && !is_empty;

    // Storage is not reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= io.BUS;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy tracks accepted writes minus accepted reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            case ({wr, rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; clear_err wins over a simultaneous set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (io.clear_err) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (io.load && is_full && !io.pop) begin
                overflow_q <= 1'b1;
            end
            if (io.pop && is_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign io.DOUT      = is_empty ? '0 : mem[rd_ptr];
    assign io.empty     = is_empty;
    assign io.full      = is_full;
    assign io.count     = count_q;
    assign io.overflow  = overflow_q;
    assign io.underflow = underflow_q;
endmodule

// File: tb/tb_bus_capture_fifo.sv
// Bench for bus_capture_fifo: directed scenarios plus randomized load/pop
// traffic against a queue-based model; popped words are checked by a monitor.
module tb_bus_capture_fifo;
    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    bus_capture_fifo_if #(.WIDTH(W), .DEPTH(DEPTH)) io ();

    bus_capture_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents and sticky flags after the last edge.
    logic [W-1:0] m_q[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    // Scoreboard: words the consumer should see, in order.
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        logic [W-1:0] head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        chk({tag, " count"},     32'(io.count),     32'(m_q.size()));
        chk({tag, " empty"},     32'(io.empty),     32'(m_q.size() == 0));
        chk({tag, " full"},      32'(io.full),      32'(m_q.size() == DEPTH));
        chk({tag, " DOUT"},      32'(io.DOUT),      32'(head));
        chk({tag, " overflow"},  32'(io.overflow),  32'(m_ovf));
        chk({tag, " underflow"}, 32'(io.underflow), 32'(m_unf));
    endtask

    // driver: called at posedge+1; applies one cycle of inputs, predicts the
    // edge with the model, then checks status after the edge.
    task automatic step(input bit ld, input bit pp, input logic [W-1:0] d,
                        input bit clr, input string tag);
        int sz;
        sz           = m_q.size();
        io.load      = ld;
        io.pop       = pp;
        io.clear_err = clr;
        io.BUS       = ld ? d : 'z;
        if (pp && sz > 0) exp_q.push_back(m_q.pop_front());
        if (ld && (sz < DEPTH || pp)) m_q.push_back(d);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (ld && sz == DEPTH && !pp) m_ovf = 1'b1;
            if (pp && sz == 0) m_unf = 1'b1;
        end
        @(posedge clk);
        #1;
        check_status(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 16 && m_q.size() > 0; i++) step(1'b0, 1'b1, '0, 1'b0, tag);
    endtask

    // monitor: at the falling edge, an accepted pop presents its word on DOUT.
    always @(negedge clk) begin : monitor
        logic [W-1:0] w;
        if (!reset && io.pop && !io.empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: DOUT=0x%0h, no word expected (t=%0t)", io.DOUT, $time);
            end else begin
                w = exp_q.pop_front();
                chk("pop_data", 32'(io.DOUT), 32'(w));
            end
        end
    end

    initial begin : stim
        logic [W-1:0] fill_words [4];
        fill_words[0] = 16'h1234;
        fill_words[1] = 16'hABCD;
        fill_words[2] = 16'h00FF;
        fill_words[3] = 16'h8001;

        reset        = 1'b1;
        io.load      = 1'b0;
        io.pop       = 1'b0;
        io.clear_err = 1'b0;
        io.BUS       = 'z;
        repeat (2) @(posedge clk);
        #1;
        check_status("reset_hold");
        reset = 1'b0;

        // idle with floating bus
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0, "idle");
        chk("idle DOUT zero", 32'(io.DOUT), 32'h0);

        // fill and drain
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill_words[i], 1'b0, "fill");
        chk("fill full", 32'(io.full), 32'd1);
        chk("fill head", 32'(io.DOUT), 32'h1234);
        drain("drain");
        chk("drain empty", 32'(io.empty), 32'd1);

        // overflow drops the word
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill_words[i], 1'b0, "fill2");
        step(1'b1, 1'b0, 16'hDEAD, 1'b0, "overflow");
        chk("overflow flag", 32'(io.overflow), 32'd1);
        chk("overflow count", 32'(io.count), 32'd4);
        drain("drain2");
        step(1'b0, 1'b0, '0, 1'b1, "clear_ovf");
        chk("overflow cleared", 32'(io.overflow), 32'd0);

        // load + pop while full
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, fill_words[i], 1'b0, "fill3");
        step(1'b1, 1'b1, 16'h5555, 1'b0, "full_ldpop");
        chk("full_ldpop head", 32'(io.DOUT), 32'hABCD);
        chk("full_ldpop no ovf", 32'(io.overflow), 32'd0);
        drain("drain3");

        // load + pop while empty
        step(1'b1, 1'b1, 16'h7777, 1'b0, "empty_ldpop");
        chk("empty_ldpop unf", 32'(io.underflow), 32'd1);
        chk("empty_ldpop DOUT", 32'(io.DOUT), 32'h7777);
        step(1'b0, 1'b0, '0, 1'b1, "clear_unf");

        // interleaved traffic across pointer wrap
        for (int i = 0; i < 10; i++)
            step(1'b1, (i % 2) == 1, W'($urandom), 1'b0, "interleave");
        drain("drain4");

        // asynchronous reset mid-cycle with three words stored
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(16'h0101 * (i + 1)), 1'b0, "pre_reset");
        io.load = 1'b0;
        io.pop  = 1'b0;
        io.BUS  = 'z;
        #2;
        reset = 1'b1;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk("async_reset count", 32'(io.count), 32'd0);
        chk("async_reset empty", 32'(io.empty), 32'd1);
        chk("async_reset DOUT", 32'(io.DOUT), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 16'h0042, 1'b0, "post_reset");
        chk("post_reset DOUT", 32'(io.DOUT), 32'h0042);

        // randomized traffic: load-heavy, then pop-heavy, then balanced
        for (int i = 0; i < 400; i++) begin
            int lp;
            int pp;
            lp = (i < 130) ? 75 : (i < 260) ? 25 : 50;
            pp = (i < 130) ? 25 : (i < 260) ? 75 : 50;
            step($urandom_range(0, 99) < lp, $urandom_range(0, 99) < pp,
                 W'($urandom), $urandom_range(0, 15) == 0, "random");
        end

        drain("final_drain");
        step(1'b0, 1'b0, '0, 1'b0, "final_idle");
        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
